// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA definitions for the fetch stage: widths, opcodes and FSM state encoding.
package instr_fetch_unit_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned IMEM_DATA_W = 32;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_ADD  = 4'h1;
  localparam logic [3:0] OPC_SUB  = 4'h2;
  localparam logic [3:0] OPC_AND  = 4'h3;
  localparam logic [3:0] OPC_OR   = 4'h4;
  localparam logic [3:0] OPC_XOR  = 4'h5;
  localparam logic [3:0] OPC_SHF  = 4'h6;
  localparam logic [3:0] OPC_LDI  = 4'h7;
  localparam logic [3:0] OPC_LD   = 4'h8;
  localparam logic [3:0] OPC_ST   = 4'h9;
  localparam logic [3:0] OPC_CMP  = 4'hA;
  localparam logic [3:0] OPC_BEQ  = 4'hB;
  localparam logic [3:0] OPC_BNE  = 4'hC;
  localparam logic [3:0] OPC_CALL = 4'hD;
  localparam logic [3:0] OPC_RET  = 4'hE;
  localparam logic [3:0] OPC_JMP  = 4'hF;

  typedef enum logic [0:0] {
    StFetch = 1'b0,
    StHalt  = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-4];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and downstream control.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic                   imem_read;
  logic [ADDR_W-1:0]      imem_addr;
  logic [IMEM_DATA_W-1:0] imem_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_W-1:0]     out_instr;
  logic [ADDR_W-1:0]      out_pc;
  logic                   redirect_valid;
  logic [ADDR_W-1:0]      redirect_pc;
  logic                   halt_req;
  logic                   halted;

  // master: the fetch unit itself
  modport master (
    output imem_read, imem_addr, out_valid, out_instr, out_pc, halted,
    input  imem_data, out_ready, redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  imem_read, imem_addr, out_valid, out_instr, out_pc, halted,
    output imem_data, out_ready, redirect_valid, redirect_pc, halt_req
  );

endinterface

// File: rtl/instr_fetch_unit_predecode.sv
// Combinational jump pre-decode: picks the next PC as jump target or PC+1 (wrapping).
module instr_fetch_unit_predecode
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [3:0] JMP_OPC = OPC_JMP
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  pc,
  output logic               is_jump,
  output logic [ADDR_W-1:0]  next_pc
);

  // Bits [11:8] of a jump are don't-care; the target is the low byte.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[11:8];

  assign is_jump = (opcode_of(instr) == JMP_OPC);
  assign next_pc = is_jump ? instr[ADDR_W-1:0] : pc + ADDR_W'(1);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, reads instruction memory and presents one registered
// instruction at a time to decode, with zero-bubble jumps, redirects and halt.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        JMP_OPC  = OPC_JMP
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic               out_valid_q, out_valid_d;

  logic [INSTR_W-1:0] instr_in;
  logic               slot_free;
  logic               fetch;
  logic               is_jump;
  logic [ADDR_W-1:0]  fetch_next_pc;

  logic unused_imem_bits;
  assign unused_imem_bits = ^bus.imem_data[IMEM_DATA_W-1:INSTR_W];
  assign instr_in         = bus.imem_data[INSTR_W-1:0];

  instr_fetch_unit_predecode #(
    .JMP_OPC (JMP_OPC)
  ) u_fetch_predecode (
    .instr   (instr_in),
    .pc      (pc_q),
    .is_jump (is_jump),
    .next_pc (fetch_next_pc)
  );

  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    // rst gates the read so memory sees no access while reset is asserted
    fetch = !rst && (state_q == StFetch) && slot_free && !bus.redirect_valid && !bus.halt_req;

    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StFetch: begin
        if (bus.redirect_valid || bus.halt_req) begin
          // Held instruction is dropped even if decode is accepting it now.
          if (bus.redirect_valid) pc_d = bus.redirect_pc;
          if (bus.halt_req)       state_d = StHalt;
          out_valid_d = 1'b0;
        end else if (fetch) begin
          out_instr_d = instr_in;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = fetch_next_pc;
        end else if (slot_free) begin
          out_valid_d = 1'b0;
        end
      end
      StHalt: begin
        out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.imem_read = fetch;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.halted    = (state_q == StHalt);

  // Sanity: a jump outcome is only taken on a cycle that actually fetches.
  logic unused_is_jump;
  assign unused_is_jump = is_jump;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the single-cycle CPU, sitting directly upstream of the 256-entry × 16-bit instruction memory bank.
- Holds the program counter and drives the memory's read-enable and 8-bit address.
- Captures the returned 16-bit instruction into an output register, handshaked to decode.
- Pre-decodes unconditional jumps (opcode 4'hF) for zero-bubble redirect, and accepts branch redirects and halt requests from downstream.

## Interface
- ADDR_W, 8, program-counter and memory address width
- INSTR_W, 16, instruction width; memory data bits above INSTR_W are ignored
- RESET_PC, 8'd0, PC value loaded on reset
- JMP_OPC, 4'hF, opcode in instr[15:12] treated as unconditional jump
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_read  out  1  read enable to instruction memory
- imem_addr  out  ADDR_W  address to instruction memory (equals PC)
- imem_data  in  32  memory read data, same-cycle combinational; only [INSTR_W-1:0] used
- out_valid  out  1  out_instr/out_pc hold a valid instruction
- out_ready  in  1  decode accepts the held instruction this cycle
- out_instr  out  INSTR_W  registered instruction
- out_pc  out  ADDR_W  address the held instruction was fetched from
- redirect_valid  in  1  downstream branch taken; flush and restart fetch
- redirect_pc  in  ADDR_W  redirect target
- halt_req  in  1  stop fetching permanently until reset
- halted  out  1  unit is in HALT state

## Operation
- States:
  - FETCH (reset state).
  - HALT: absorbing; exit only via rst.
- slot_free = !out_valid || out_ready.
- Fetch occurs when state==FETCH && slot_free && !redirect_valid && !halt_req.
- imem_read = fetch; imem_addr = pc at all times (combinational).
- On fetch:
  - out_instr <= imem_data[15:0]; out_pc <= pc; out_valid <= 1.
  - Next pc: if instr[15:12]==JMP_OPC, pc <= instr[7:0] (bits [11:8] ignored); else pc <= pc+1, modulo 256 (255 wraps to 0).
- Slot occupied and out_ready low: out_instr, out_pc, out_valid, pc all hold.
- Slot free but no fetch (e.g. halted): out_valid <= 0.
- redirect_valid (FETCH state): pc <= redirect_pc; out_valid <= 0 (held instruction dropped regardless of out_ready); no fetch that cycle.
- halt_req (FETCH state): state <= HALT; out_valid <= 0; pc holds. If redirect_valid is also set, pc <= redirect_pc, then halt.
- In HALT: redirect_valid and halt_req ignored; imem_read=0; halted=1.
- Jumps are forwarded to decode like any other instruction (out_valid set).

## Timing
- Reset values: pc=RESET_PC, state=FETCH, out_valid=0, out_instr=0, out_pc=0, halted=0. imem_read=0 while rst is high.
- rst overrides every other input in the same cycle, including mid-stall, mid-redirect and in HALT.
- Latency: address to out_instr is 1 cycle. First out_valid is the cycle after rst deasserts.
- Throughput: 1 instruction/cycle with out_ready held high, including across jumps (no bubble).
- Redirect costs exactly one bubble cycle: out_valid=0 in the cycle after redirect_valid.
- halted rises the cycle after halt_req is sampled.

## Structure
- Shared header isa_defs: ADDR_W, INSTR_W, opcode constants (JMP_OPC and the other 4-bit opcodes), state encodings FETCH=1'b0, HALT=1'b1.
- One sub-module: fetch_predecode, combinational. It takes instruction and pc and returns is_jump and next_pc, covering jump target and +1 wrap.

## Test plan
- Reset, then free-run with out_ready=1 over program 0008,7280,72C0,1100,1152,994A,1902,0308,7380,BC82,CCC3,F004 → out_pc sequence 0..11, then 4,5,…; out_instr at pc 11 = 16'hF004, next out_pc=4 with no gap.
- Backpressure: drop out_ready for 3 cycles while holding pc 2 → out_instr=16'h72C0, out_pc=2 stable, imem_read=0; resume and get pc 3 next.
- Redirect: redirect_valid with redirect_pc=8'd12 while out_pc=5 is held → one cycle out_valid=0, then out_pc=12.
- Wrap: redirect to 255 with a non-jump there → out_pc 255 then 0.
- Halt: halt_req with redirect_valid (pc 9) at out_pc=3 → halted=1 next cycle, out_valid=0, imem_read=0 thereafter; pc=9.
- Reset mid-operation (during a stall and again in HALT) → next cycle all outputs at reset values, fetch restarts at RESET_PC.
